// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_e;

    localparam int PORT0 = 0;
    localparam int PORT1 = 1;

    // Wide enough for the largest legal latency (15).
    localparam int CNT_W = $clog2(16);

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select for the memory arbiter.
// Tie-break policy: MEM_ARB_ROUND_ROBIN_EN defined -> round robin, otherwise port 0 wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic [1:0] last_i,
    output logic [1:0] pick_o
);

    always_comb begin
        // NOTE: assigning a default before any branch keeps this purely combinational (no latch).
        pick_o = 2'b00;
        if (req_i[PORT0] && req_i[PORT1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            pick_o = (last_i == 2'b01) ? 2'b10 : 2'b01;
`else
            pick_o = 2'b01;
`endif
        end else if (req_i[PORT0]) begin
            pick_o = 2'b01;
        end else if (req_i[PORT1]) begin
            pick_o = 2'b10;
        end
    end

`ifndef MEM_ARB_ROUND_ROBIN_EN
    logic unused_last;
    assign unused_last = ^last_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of the single memory controller: one transaction at a time,
// one strobe, fixed latency, one-cycle ack. Build option: MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_read_en,
    output logic                  mem_write_en,
    input  logic                  mem_busy,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [1:0]            grant
);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  rd_en_q, rd_en_d;
    logic                  wr_en_q, wr_en_d;
    logic [1:0]            ack_q, ack_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic [1:0]            req;
    logic [1:0]            pick;
    logic [1:0]            last;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    assign req       = {m1_req, m0_req};
    assign sel_we    = pick[PORT1] ? m1_we    : m0_we;
    assign sel_addr  = pick[PORT1] ? m1_addr  : m0_addr;
    assign sel_wdata = pick[PORT1] ? m1_wdata : m0_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [1:0] last_q, last_d;
    assign last = last_q;
`else
    // Fixed priority ignores history; a constant stands in for the pointer.
    assign last = 2'b10;
`endif

    mem_arb_pick u_pick (
        .req_i  (req),
        .last_i (last),
        .pick_o (pick)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        rd_en_d  = 1'b0;
        wr_en_d  = 1'b0;
        ack_d    = 2'b00;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_d   = last_q;
`endif

        case (state_q)
            IDLE: begin
                if ((|req) && !mem_busy) begin
                    grant_d = pick;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    we_d    = sel_we;
                    rd_en_d = !sel_we;
                    wr_en_d = sel_we;
                    cnt_d   = CNT_W'(MEM_LATENCY);
                    state_d = ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_d  = pick;
`endif
                end
            end
            ACCESS: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Counter reaches zero on this edge: data is captured and ack launched together.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ACK;
                    ack_d   = grant_q;
                    if (!we_q) begin
                        if (grant_q[PORT0]) rdata0_d = mem_data_out;
                        if (grant_q[PORT1]) rdata1_d = mem_data_out;
                    end
                end
            end
            ACK: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            grant_q  <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            ack_q    <= 2'b00;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q   <= 2'b10;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            rd_en_q  <= rd_en_d;
            wr_en_q  <= wr_en_d;
            ack_q    <= ack_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q   <= last_d;
`endif
        end
    end

    assign m0_ack       = ack_q[PORT0];
    assign m1_ack       = ack_q[PORT1];
    assign m0_rdata     = rdata0_q;
    assign m1_rdata     = rdata1_q;
    assign mem_addr     = addr_q;
    assign mem_data_in  = wdata_q;
    assign mem_read_en  = rd_en_q;
    assign mem_write_en = wr_en_q;
    assign grant        = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a scoreboard of expected transactions is checked
// at every strobe and ack, against a behavioural memory behind the arbiter.
module tb_mem_arbiter;

    localparam int AW  = 16;
    localparam int DW  = 8;
    localparam int LAT = 2;

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic          mem_read_en, mem_write_en;
    logic          mem_busy = 1'b0;
    logic [DW-1:0] mem_data_out = '0;
    logic [1:0]    grant;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            last_strobe = 0;
    logic          prev_strobe = 1'b0;
    int            strobe_cycles[$];
    txn_t          sb[$];
    txn_t          mon_e;
    logic [DW-1:0] exp_rd[2];
    logic [DW-1:0] mem[65536];
    int            order[4];

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .m0_req       (m0_req),
        .m0_we        (m0_we),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_ack       (m0_ack),
        .m0_rdata     (m0_rdata),
        .m1_req       (m1_req),
        .m1_we        (m1_we),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_ack       (m1_ack),
        .m1_rdata     (m1_rdata),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_busy     (mem_busy),
        .mem_data_out (mem_data_out),
        .grant        (grant)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic port, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rexp);
        txn_t t;
        t.port  = port;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        if (!we) exp_rd[port] = rexp;
        t.rdata = exp_rd[port];
        sb.push_back(t);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic port);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(port ? m1_ack : m0_ack) && n < 100);
        check(port ? "ack_seen_m1" : "ack_seen_m0", port ? m1_ack : m0_ack, 1'b1);
    endtask

    function automatic logic [63:0] all_outputs();
        return {m0_ack, m1_ack, m0_rdata, m1_rdata, mem_addr, mem_data_in,
                mem_read_en, mem_write_en, grant};
    endfunction

    // Behavioural memory controller: data appears mid-strobe and stays until the next read.
    always @(negedge clk) begin
        if (mem_write_en) mem[mem_addr] = mem_data_in;
        if (mem_read_en)  mem_data_out = mem[mem_addr];
    end

    // Monitor: protocol invariants, strobe contents and ack results against the scoreboard.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("invariants",
                  {(m0_ack & m1_ack), (mem_read_en & mem_write_en), (&grant),
                   (prev_strobe & (mem_read_en | mem_write_en))}, 4'b0000);
            if (mem_read_en | mem_write_en) begin
                strobe_cycles.push_back(cyc);
                last_strobe = cyc;
                if (sb.size() == 0) begin
                    check("strobe_expected", 1'b0, 1'b1);
                end else begin
                    check("strobe_we",    mem_write_en, sb[0].we);
                    check("strobe_addr",  mem_addr, sb[0].addr);
                    check("strobe_grant", grant, sb[0].port ? 2'b10 : 2'b01);
                    if (sb[0].we) check("strobe_wdata", mem_data_in, sb[0].wdata);
                end
            end
            if (m0_ack | m1_ack) begin
                if (sb.size() == 0) begin
                    check("ack_expected", 1'b0, 1'b1);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_port",     {m1_ack, m0_ack}, mon_e.port ? 2'b10 : 2'b01);
                    check("ack_grant",    grant, mon_e.port ? 2'b10 : 2'b01);
                    check("ack_latency",  cyc - last_strobe, LAT);
                    check("ack_rdata",    mon_e.port ? m1_rdata : m0_rdata, mon_e.rdata);
                end
            end
        end
        prev_strobe = mem_read_en | mem_write_en;
    end

    initial begin
        int n;
        int n0;
        int acks;

        exp_rd[0] = '0;
        exp_rd[1] = '0;
        mem[16'h0010] = 8'h77;
        mem[16'h1234] = 8'hA5;
        mem[16'h0100] = 8'h11;
        mem[16'h0200] = 8'h22;
        mem[16'h0300] = 8'h99;
        mem[16'h0400] = 8'h5A;
        mem[16'h0500] = 8'hC3;
        mem[16'h0001] = 8'h0F;

        // Reset state
        #2 reset = 1'b1;
        idle(2);
        check("reset_outputs", all_outputs(), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // 1: busy blocks grants; strobe one cycle after busy falls
        mem_busy = 1'b1;
        push(1'b0, 1'b0, 16'h0010, 8'h00, 8'h77);
        m0_we = 1'b0; m0_addr = 16'h0010; m0_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("busy_hold", {grant, mem_read_en, mem_write_en}, 4'b0000);
        end
        @(posedge clk); #1;
        mem_busy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("busy_release_strobe", mem_read_en, 1'b1);
        wait_ack(1'b0);
        @(posedge clk); #1;
        m0_req = 1'b0;
        idle(2);

        // 2: m0 read 0x1234 -> 0xA5
        push(1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5);
        m0_we = 1'b0; m0_addr = 16'h1234; m0_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t2_strobe", {mem_read_en, mem_addr}, {1'b1, 16'h1234});
        wait_ack(1'b0);
        check("t2_rdata", m0_rdata, 8'hA5);
        @(posedge clk); #1;
        m0_req = 1'b0;
        idle(2);

        // 3: m1 write 0xFFFF <- 0x3C, rdata untouched
        push(1'b1, 1'b1, 16'hFFFF, 8'h3C, 8'h00);
        m1_we = 1'b1; m1_addr = 16'hFFFF; m1_wdata = 8'h3C; m1_req = 1'b1;
        wait_ack(1'b1);
        check("t3_rdata_unchanged", m1_rdata, 8'h00);
        @(posedge clk); #1;
        m1_req = 1'b0; m1_we = 1'b0;
        idle(1);
        check("t3_mem_written", mem[16'hFFFF], 8'h3C);
        idle(1);

        // 4: both requesters held for four transactions
`ifdef MEM_ARB_ROUND_ROBIN_EN
        order[0] = 0; order[1] = 1; order[2] = 0; order[3] = 1;
`else
        order[0] = 0; order[1] = 0; order[2] = 0; order[3] = 0;
`endif
        for (int i = 0; i < 4; i++)
            push(order[i][0], 1'b0, order[i] == 1 ? 16'h0200 : 16'h0100, 8'h00,
                 order[i] == 1 ? 8'h22 : 8'h11);
        m0_we = 1'b0; m0_addr = 16'h0100; m0_req = 1'b1;
        m1_we = 1'b0; m1_addr = 16'h0200; m1_req = 1'b1;
        acks = 0;
        n = 0;
        while (acks < 4 && n < 200) begin
            @(negedge clk);
            n++;
            if (m0_ack | m1_ack) acks++;
        end
        check("t4_ack_count", acks, 4);
        @(posedge clk); #1;
        m0_req = 1'b0; m1_req = 1'b0;
        idle(2);
        check("t4_sb_drained", sb.size(), 0);
        sb.delete();

        // 5: reset mid-ACCESS drops the transaction
        push(1'b0, 1'b0, 16'h0300, 8'h00, 8'h99);
        m0_we = 1'b0; m0_addr = 16'h0300; m0_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_read_en && n < 50);
        check("t5_strobe", mem_read_en, 1'b1);
        #2 reset = 1'b1;
        #1 check("t5_reset_outputs", all_outputs(), 64'd0);
        sb.delete();
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        m0_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("t5_no_ack", {m1_ack, m0_ack, grant}, 4'b0000);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);
        push(1'b1, 1'b0, 16'h0400, 8'h00, 8'h5A);
        m1_we = 1'b0; m1_addr = 16'h0400; m1_req = 1'b1;
        wait_ack(1'b1);
        check("t5_m1_rdata", m1_rdata, 8'h5A);
        @(posedge clk); #1;
        m1_req = 1'b0;
        idle(2);

        // 6: m0 holds req through ack with a new address; strobes MEM_LATENCY+2 apart
        n0 = strobe_cycles.size();
        push(1'b0, 1'b0, 16'h0500, 8'h00, 8'hC3);
        m0_we = 1'b0; m0_addr = 16'h0500; m0_req = 1'b1;
        wait_ack(1'b0);
        push(1'b0, 1'b0, 16'h0001, 8'h00, 8'h0F);
        @(posedge clk); #1;
        m0_addr = 16'h0001;
        wait_ack(1'b0);
        check("t6_rdata", m0_rdata, 8'h0F);
        @(posedge clk); #1;
        m0_req = 1'b0;
        idle(3);
        check("t6_strobe_count", strobe_cycles.size() - n0, 2);
        if (strobe_cycles.size() - n0 >= 2)
            check("t6_interval", strobe_cycles[n0 + 1] - strobe_cycles[n0], LAT + 2);
        check("final_sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, required $finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
